// File: rtl/serial_pkg.sv
// Shared line-level and FSM encoding definitions for the serial link.
// The matching transmitter imports this package too.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_shift_reg.sv
// WIDTH-bit serial-in/parallel-out register with shift enable, selectable
// shift direction and synchronous clear.
module rx_shift_reg #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (shift_en) begin
            // First bit shifted in ends up at the far end after WIDTH shifts.
            if (MSB_FIRST) begin
                q_d = {q_q[WIDTH-2:0], serial_in};
            end else begin
                q_d = {serial_in, q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start detect, WIDTH-bit deserialize, optional even
// parity and stop check, feeding a one-entry valid/ready output buffer.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          PARITY    = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             pe_q, pe_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;

    logic             shift_en;
    logic [WIDTH-1:0] shift_val;

    assign shift_en = bit_en && (state_q == ST_DATA);

    rx_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .clear     (clear),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .q         (shift_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        perr_d  = perr_q;
        data_d  = data_q;
        valid_d = valid_q && !out_ready;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        if (bit_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (serial_in == START_BIT) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
                    end
                end
                ST_DATA: begin
                    par_d = par_q ^ serial_in;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (PARITY) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PARITY: begin
                    perr_d  = par_q ^ serial_in;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    // Framing error outranks parity; a full buffer that is
                    // draining this cycle still accepts the new word.
                    if (serial_in != STOP_BIT) begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end else begin
                        state_d = ST_IDLE;
                        if (perr_q) begin
                            pe_d = 1'b1;
                        end else if (valid_q && !out_ready) begin
                            ov_d = 1'b1;
                        end else begin
                            data_d  = shift_val;
                            valid_d = 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (serial_in == LINE_IDLE) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign data_out   = data_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized bench for serial_frame_rx (default parameters) against a
// frame-level reference model of the output buffer and error pulses.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       clear;
    logic       bit_en;
    logic       serial_in;
    logic [3:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_busy;
    logic [3:0] cur_d;
    logic       cur_flip;
    int         max_gap;

    serial_frame_rx u_dut (
        .clk        (clk),
        .clear      (clear),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic pe, input logic fe, input logic ov);
        check_eq("data_out", 32'(data_out), 32'(m_data));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("parity_err", 32'(parity_err), 32'(pe));
        check_eq("frame_err", 32'(frame_err), 32'(fe));
        check_eq("overrun", 32'(overrun), 32'(ov));
    endtask

    // kind: 0 plain, 1 start sample, 2 stop sample, 3 break-exit sample
    task automatic cyc(input logic en, input logic sin, input int kind);
        logic pe, fe, ov;
        pe = 1'b0;
        fe = 1'b0;
        ov = 1'b0;
        bit_en    = en;
        serial_in = sin;
        @(posedge clk);
        if (en && kind == 2) begin
            if (!sin) begin
                fe      = 1'b1;
                m_valid = m_valid && !out_ready;
            end else begin
                m_busy = 1'b0;
                if (cur_flip) begin
                    pe      = 1'b1;
                    m_valid = m_valid && !out_ready;
                end else if (m_valid && !out_ready) begin
                    ov = 1'b1;
                end else begin
                    m_data  = cur_d;
                    m_valid = 1'b1;
                end
            end
        end else begin
            m_valid = m_valid && !out_ready;
            if (en && kind == 1) m_busy = 1'b1;
            if (en && kind == 3) m_busy = 1'b0;
        end
        #1;
        check_outputs(pe, fe, ov);
        bit_en = 1'b0;
    endtask

    task automatic gap();
        int n;
        n = (max_gap == 0) ? 0 : int'($urandom_range(max_gap));
        repeat (n) cyc(1'b0, 1'($urandom_range(1)), 0);
    endtask

    task automatic do_clear();
        clear  = 1'b1;
        bit_en = 1'($urandom_range(1));
        @(posedge clk);
        #1;
        clear   = 1'b0;
        bit_en  = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        check_outputs(1'b0, 1'b0, 1'b0);
    endtask

    // Data sent first bit = d[3] so it lands in data_out[3].
    task automatic send_frame(input logic [3:0] d, input logic flip, input logic stop_b);
        cur_d    = d;
        cur_flip = flip;
        gap();
        cyc(1'b1, 1'b0, 1);
        for (int i = 3; i >= 0; i--) begin
            gap();
            cyc(1'b1, d[i], 0);
        end
        gap();
        cyc(1'b1, (^d) ^ flip, 0);
        gap();
        cyc(1'b1, stop_b, 2);
    endtask

    task automatic recover_break(input int zeros);
        repeat (zeros) begin
            gap();
            cyc(1'b1, 1'b0, 0);
        end
        gap();
        cyc(1'b1, 1'b1, 3);
    endtask

    initial begin
        clear     = 1'b1;
        bit_en    = 1'b0;
        serial_in = 1'b1;
        out_ready = 1'b1;
        max_gap   = 0;
        m_data    = '0;
        m_valid   = 1'b0;
        m_busy    = 1'b0;
        cur_d     = '0;
        cur_flip  = 1'b0;
        @(posedge clk);
        do_clear();

        // Good frame, then bad parity followed by a good 1010
        send_frame(4'b1101, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 0);
        send_frame(4'b1101, 1'b1, 1'b1);
        send_frame(4'b1010, 1'b0, 1'b1);

        // Framing break held low, released by a 1, then a good frame
        send_frame(4'b0011, 1'b0, 1'b0);
        recover_break(5);
        send_frame(4'b0110, 1'b0, 1'b1);

        // Overrun with a stalled consumer, then drain
        out_ready = 1'b0;
        send_frame(4'b1101, 1'b0, 1'b1);
        send_frame(4'b1010, 1'b0, 1'b1);
        out_ready = 1'b1;
        cyc(1'b0, 1'b1, 0);
        cyc(1'b0, 1'b0, 0);

        // Strobe gaps with glitches on idle cycles
        max_gap = 1;
        send_frame(4'b1101, 1'b0, 1'b1);

        // Clear mid-frame after two data bits
        max_gap = 0;
        cur_d   = 4'b1001;
        cyc(1'b1, 1'b0, 1);
        cyc(1'b1, 1'b1, 0);
        cyc(1'b1, 1'b0, 0);
        do_clear();
        send_frame(4'b0110, 1'b0, 1'b1);

        // Randomized frames: errors, stalls, gaps and back-to-back starts
        max_gap = 2;
        for (int f = 0; f < 300; f++) begin
            out_ready = ($urandom_range(3) != 0);
            send_frame(4'($urandom_range(15)), ($urandom_range(7) == 0),
                       ($urandom_range(7) != 0));
            if (frame_err) recover_break(int'($urandom_range(3)));
            if ($urandom_range(3) == 0) cyc(1'b1, 1'b1, 0);
        end
        out_ready = 1'b1;
        cyc(1'b0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
